uart_frame_link: RTL and testbench

Framed, multi-channel link layer that sits between the byte-level uart core (rx_data/rx_valid, tx_data/tx_valid/tx_ready) and the board I/O logic.
- RX side parses checksummed frames into per-channel output registers (LEDs, segment elements).
- TX side periodically, or on request, serialises per-channel input snapshots (switches, buttons) into frames.
- Generalises the fixed single-stream shift-register/FIFO path to N channels of M bytes each, with error detection and timeout.

---
 rtl/uart_frame_link.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_uart_frame_link.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_link.sv
// Framed multi-channel link layer between a byte-level uart core and board I/O.
// Define UART_FRAME_LINK_STATS_EN to build the saturating good/error frame counters.
module uart_frame_link #(
  parameter int          NUM_CHANNELS  = 4,
  parameter int          CHANNEL_BYTES = 2,
  parameter logic [7:0]  SOF_BYTE      = 8'hA5,
  parameter int          TX_PERIOD     = 5_000_000,
  parameter int          RX_TIMEOUT    = 50_000
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      ena,
  input  logic [7:0]                                rx_data,
  input  logic                                      rx_valid,
  output logic [7:0]                                tx_data,
  output logic                                      tx_valid,
  input  logic                                      tx_ready,
  input  logic [NUM_CHANNELS*CHANNEL_BYTES*8-1:0]   in_data,
  input  logic                                      send_req,
  output logic [NUM_CHANNELS*CHANNEL_BYTES*8-1:0]   out_data,
  output logic [NUM_CHANNELS-1:0]                   out_update,
  output logic                                      frame_error,
  output logic                                      tx_busy,
  output logic [15:0]                               good_count,
  output logic [15:0]                               err_count
);

  localparam int SLOT_W = CHANNEL_BYTES * 8;
  localparam int W      = NUM_CHANNELS * SLOT_W;

  typedef enum logic [1:0] {R_IDLE, R_CHAN, R_PAY, R_CSUM} rx_state_e;
  typedef enum logic [2:0] {T_IDLE, T_SOF, T_CHAN, T_PAY, T_CSUM} tx_state_e;

  rx_state_e               rx_state_q, rx_state_d;
  logic [6:0]              rx_chan_q, rx_chan_d;
  logic [7:0]              rx_csum_q, rx_csum_d;
  logic [4:0]              rx_cnt_q, rx_cnt_d;
  logic [SLOT_W-1:0]       rx_shadow_q, rx_shadow_d;
  logic [31:0]             rx_tmo_q, rx_tmo_d;
  logic [W-1:0]            out_data_q, out_data_d;
  logic [NUM_CHANNELS-1:0] out_update_q, out_update_d;
  logic                    frame_error_q, frame_error_d;
  logic                    commit_s;

  tx_state_e               tx_state_q, tx_state_d;
  logic [6:0]              tx_chan_q, tx_chan_d;
  logic [4:0]              tx_cnt_q, tx_cnt_d;
  logic [7:0]              tx_csum_q, tx_csum_d;
  logic [SLOT_W-1:0]       tx_shift_q, tx_shift_d;
  logic [W-1:0]            tx_snap_q, tx_snap_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    tx_busy_q, tx_busy_d;
  logic                    pending_q, pending_d;
  logic [31:0]             timer_q, timer_d;
  logic                    timer_hit_s, trigger_s, xfer_s;
  logic [SLOT_W-1:0]       tx_slot_s;

  // RX parser: frame assembly, checksum verification and idle timeout
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_chan_d     = rx_chan_q;
    rx_csum_d     = rx_csum_q;
    rx_cnt_d      = rx_cnt_q;
    rx_shadow_d   = rx_shadow_q;
    rx_tmo_d      = rx_tmo_q;
    out_data_d    = out_data_q;
    out_update_d  = '0;
    frame_error_d = 1'b0;
    commit_s      = 1'b0;
    if (rx_valid) begin
      rx_tmo_d = 32'd0;
      case (rx_state_q)
        R_IDLE: begin
          if (rx_data == SOF_BYTE) rx_state_d = R_CHAN;
          else                     rx_state_d = R_IDLE;
        end
        R_CHAN: begin
          if (rx_data >= 8'(NUM_CHANNELS)) begin
            frame_error_d = 1'b1;
            rx_state_d    = R_IDLE;
          end else begin
            rx_chan_d  = rx_data[6:0];
            rx_csum_d  = rx_data;
            rx_cnt_d   = 5'd0;
            rx_state_d = R_PAY;
          end
        end
        R_PAY: begin
          rx_shadow_d = SLOT_W'(rx_shadow_q << 8) | SLOT_W'(rx_data);
          rx_csum_d   = rx_csum_q ^ rx_data;
          if (rx_cnt_q == 5'(CHANNEL_BYTES - 1)) rx_state_d = R_CSUM;
          else                                   rx_cnt_d   = rx_cnt_q + 5'd1;
        end
        R_CSUM: begin
          if (rx_data == rx_csum_q) begin
            commit_s = 1'b1;
            out_data_d[rx_chan_q*SLOT_W +: SLOT_W] = rx_shadow_q;
            out_update_d = NUM_CHANNELS'(1'b1) << rx_chan_q;
          end else begin
            frame_error_d = 1'b1;
          end
          rx_state_d = R_IDLE;
        end
        default: rx_state_d = R_IDLE;
      endcase
    end else if (rx_state_q != R_IDLE) begin
      if (rx_tmo_q == 32'(RX_TIMEOUT - 1)) begin
        frame_error_d = 1'b1;
        rx_state_d    = R_IDLE;
        rx_tmo_d      = 32'd0;
      end else begin
        rx_tmo_d = rx_tmo_q + 32'd1;
      end
    end else begin
      rx_tmo_d = 32'd0;
    end
  end

  // RX state register; a reset mid-frame simply drops the partial frame
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q    <= R_IDLE;
      rx_chan_q     <= 7'd0;
      rx_csum_q     <= 8'd0;
      rx_cnt_q      <= 5'd0;
      rx_shadow_q   <= '0;
      rx_tmo_q      <= 32'd0;
      out_data_q    <= '0;
      out_update_q  <= '0;
      frame_error_q <= 1'b0;
    end else if (ena) begin
      rx_state_q    <= rx_state_d;
      rx_chan_q     <= rx_chan_d;
      rx_csum_q     <= rx_csum_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_shadow_q   <= rx_shadow_d;
      rx_tmo_q      <= rx_tmo_d;
      out_data_q    <= out_data_d;
      out_update_q  <= out_update_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign tx_slot_s = tx_snap_q[tx_chan_q*SLOT_W +: SLOT_W];
  assign xfer_s    = tx_valid_q & tx_ready & ena;
  assign trigger_s = send_req | timer_hit_s;

  // TX period timer and burst serialiser; the checksum accumulates each byte as it leaves
  always_comb begin
    timer_d     = timer_q;
    timer_hit_s = 1'b0;
    tx_state_d  = tx_state_q;
    tx_chan_d   = tx_chan_q;
    tx_cnt_d    = tx_cnt_q;
    tx_csum_d   = tx_csum_q;
    tx_shift_d  = tx_shift_q;
    tx_snap_d   = tx_snap_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    tx_busy_d   = tx_busy_q;
    pending_d   = pending_q;
    if (TX_PERIOD == 0) begin
      timer_d = 32'd0;
    end else if (timer_q == 32'(TX_PERIOD - 1)) begin
      timer_hit_s = 1'b1;
      timer_d     = 32'd0;
    end else begin
      timer_d = timer_q + 32'd1;
    end
    if (trigger_s && tx_busy_q) pending_d = 1'b1;
    else                        pending_d = pending_q;
    case (tx_state_q)
      T_IDLE: begin
        if (trigger_s || pending_q) begin
          tx_snap_d  = in_data;
          tx_chan_d  = 7'd0;
          tx_data_d  = SOF_BYTE;
          tx_valid_d = 1'b1;
          tx_busy_d  = 1'b1;
          pending_d  = 1'b0;
          tx_state_d = T_SOF;
        end else begin
          tx_state_d = T_IDLE;
        end
      end
      T_SOF: begin
        if (xfer_s) begin
          tx_data_d  = {1'b0, tx_chan_q};
          tx_state_d = T_CHAN;
        end else begin
          tx_state_d = T_SOF;
        end
      end
      T_CHAN: begin
        if (xfer_s) begin
          tx_csum_d  = tx_data_q;
          tx_data_d  = tx_slot_s[SLOT_W-1 -: 8];
          tx_shift_d = SLOT_W'(tx_slot_s << 8);
          tx_cnt_d   = 5'd0;
          tx_state_d = T_PAY;
        end else begin
          tx_state_d = T_CHAN;
        end
      end
      T_PAY: begin
        if (xfer_s) begin
          tx_csum_d = tx_csum_q ^ tx_data_q;
          if (tx_cnt_q == 5'(CHANNEL_BYTES - 1)) begin
            tx_data_d  = tx_csum_q ^ tx_data_q;
            tx_state_d = T_CSUM;
          end else begin
            tx_data_d  = tx_shift_q[SLOT_W-1 -: 8];
            tx_shift_d = SLOT_W'(tx_shift_q << 8);
            tx_cnt_d   = tx_cnt_q + 5'd1;
          end
        end else begin
          tx_state_d = T_PAY;
        end
      end
      T_CSUM: begin
        if (xfer_s && (tx_chan_q == 7'(NUM_CHANNELS - 1))) begin
          tx_valid_d = 1'b0;
          tx_busy_d  = 1'b0;
          tx_state_d = T_IDLE;
        end else if (xfer_s) begin
          tx_chan_d  = tx_chan_q + 7'd1;
          tx_data_d  = SOF_BYTE;
          tx_state_d = T_SOF;
        end else begin
          tx_state_d = T_CSUM;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q    <= 32'd0;
      tx_state_q <= T_IDLE;
      tx_chan_q  <= 7'd0;
      tx_cnt_q   <= 5'd0;
      tx_csum_q  <= 8'd0;
      tx_shift_q <= '0;
      tx_snap_q  <= '0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      pending_q  <= 1'b0;
    end else if (ena) begin
      timer_q    <= timer_d;
      tx_state_q <= tx_state_d;
      tx_chan_q  <= tx_chan_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_csum_q  <= tx_csum_d;
      tx_shift_q <= tx_shift_d;
      tx_snap_q  <= tx_snap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_busy_q  <= tx_busy_d;
      pending_q  <= pending_d;
    end
  end

`ifdef UART_FRAME_LINK_STATS_EN
  logic [15:0] good_q, err_q;

  // Saturating frame statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      good_q <= 16'd0;
      err_q  <= 16'd0;
    end else if (ena) begin
      if (commit_s && (good_q != 16'hFFFF))     good_q <= good_q + 16'd1;
      if (frame_error_d && (err_q != 16'hFFFF)) err_q  <= err_q + 16'd1;
    end
  end

  assign good_count = good_q;
  assign err_count  = err_q;
`else
  assign good_count = 16'd0;
  assign err_count  = 16'd0;
`endif

  assign out_data    = out_data_q;
  assign out_update  = out_update_q;
  assign frame_error = frame_error_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign tx_busy     = tx_busy_q;

endmodule

// File: tb/tb_uart_frame_link.sv
// Self-checking bench for uart_frame_link: RX frames checked directly, TX bytes via an expected-byte queue.
module tb_uart_frame_link;

  localparam int NCH    = 4;
  localparam int CB     = 2;
  localparam int W      = NCH * CB * 8;
  localparam int RX_TMO = 50_000;
`ifdef UART_FRAME_LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           ena = 1'b1;
  logic [7:0]     rx_data = 8'd0;
  logic           rx_valid = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b1;
  logic [W-1:0]   in_data = '0;
  logic           send_req = 1'b0;
  logic [W-1:0]   out_data;
  logic [NCH-1:0] out_update;
  logic           frame_error;
  logic           tx_busy;
  logic [15:0]    good_count;
  logic [15:0]    err_count;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [W-1:0] exp_out = '0;
  int         exp_good = 0;
  int         exp_err = 0;
  bit         rdy_toggle = 1'b0;
  int         rdy_phase = 0;
  logic       hold_q = 1'b0;
  logic [7:0] hold_data = 8'd0;

  uart_frame_link #(
    .NUM_CHANNELS(NCH), .CHANNEL_BYTES(CB), .SOF_BYTE(8'hA5),
    .TX_PERIOD(0), .RX_TIMEOUT(RX_TMO)
  ) dut (
    .clk(clk), .reset(reset), .ena(ena),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .in_data(in_data), .send_req(send_req),
    .out_data(out_data), .out_update(out_update), .frame_error(frame_error),
    .tx_busy(tx_busy), .good_count(good_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    check_val({tag, "_good"}, 64'(good_count), STATS ? 64'(exp_good) : 64'd0);
    check_val({tag, "_err"},  64'(err_count),  STATS ? 64'(exp_err)  : 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_send();
    @(posedge clk); #1;
    send_req = 1'b1;
    @(posedge clk); #1;
    send_req = 1'b0;
  endtask

  // Reference frame builder: one frame per channel, MSB payload byte first
  task automatic push_burst(input logic [W-1:0] d);
    logic [7:0] cs, b;
    for (int c = 0; c < NCH; c++) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(c));
      cs = 8'(c);
      for (int k = 0; k < CB; k++) begin
        b = d[c*CB*8 + (CB-1-k)*8 +: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
      exp_q.push_back(cs);
    end
  endtask

  task automatic wait_drain(input string tag, input bit chk_busy, input int budget);
    int n = 0;
    bit busy_ok = 1'b1;
    do begin
      @(posedge clk); #2;
      n++;
      if (exp_q.size() != 0 && chk_busy && !tx_busy) busy_ok = 1'b0;
    end while (exp_q.size() != 0 && n < budget);
    check_val({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check_val({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
    check_val({tag, "_busy_end"}, 64'(tx_busy), 64'd0);
  endtask

  // Transmitter model: ready always high, or high one cycle in three
  always @(posedge clk) begin
    #1;
    rdy_phase = (rdy_phase == 2) ? 0 : rdy_phase + 1;
    tx_ready  = rdy_toggle ? (rdy_phase == 0) : 1'b1;
  end

  // Scoreboard: pop on every transfer, and hold data steady across stalls
  always @(negedge clk) begin
    if (!reset && ena && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check_val("tx_unexpected_byte", 64'(exp_q.size()), 64'd1);
      else                   check_val("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
    end
    if (hold_q) check_val("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, hold_data});
    hold_q    <= !reset && tx_valid && !tx_ready;
    hold_data <= tx_data;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_val("rst_out_data", out_data, 64'd0);
    check_val("rst_update", 64'(out_update), 64'd0);
    check_val("rst_ferr", 64'(frame_error), 64'd0);
    check_val("rst_tx", {54'd0, tx_valid, tx_busy, tx_data}, 64'd0);
    check_stats("rst");

    // Good frame to channel 1
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h27);
    exp_out[31:16] = 16'h1234; exp_good++;
    check_val("rx1_update", 64'(out_update), 64'h2);
    check_val("rx1_data", out_data, exp_out);
    check_stats("rx1");
    @(posedge clk); #1;
    check_val("rx1_update_pulse", 64'(out_update), 64'h0);

    // Bad checksum, then good frame to channel 2
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    exp_err++;
    check_val("rx2_ferr", 64'(frame_error), 64'd1);
    check_val("rx2_update", 64'(out_update), 64'h0);
    check_val("rx2_data", out_data, exp_out);
    check_stats("rx2");
    @(posedge clk); #1;
    check_val("rx2_ferr_pulse", 64'(frame_error), 64'd0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h64);
    exp_out[47:32] = 16'hABCD; exp_good++;
    check_val("rx3_update", 64'(out_update), 64'h4);
    check_val("rx3_data", out_data, exp_out);

    // Out-of-range channel, trailing bytes dropped
    send_byte(8'hA5); send_byte(8'h05);
    exp_err++;
    check_val("rx4_ferr", 64'(frame_error), 64'd1);
    send_byte(8'h11);
    check_val("rx4_drop1", {63'd0, frame_error} | 64'(out_update), 64'd0);
    send_byte(8'h22);
    check_val("rx4_drop2", {63'd0, frame_error} | 64'(out_update), 64'd0);
    check_val("rx4_data", out_data, exp_out);
    check_stats("rx4");

    // Strobes with ena low are ignored; the same frame then commits
    ena = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h10);
    check_val("ena_off_update", 64'(out_update), 64'h0);
    check_val("ena_off_data", out_data, exp_out);
    ena = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h10);
    exp_out[31:16] = 16'hAABB; exp_good++;
    check_val("ena_on_update", 64'(out_update), 64'h2);
    check_val("ena_on_data", out_data, exp_out);
    check_stats("ena");

    // TX burst, ready always high
    in_data = 64'h0000_0000_0000_BEEF;
    push_burst(in_data);
    pulse_send();
    check_val("tx1_busy_start", 64'(tx_busy), 64'd1);
    wait_drain("tx1", 1'b1, 500);
    check_val("tx1_valid_end", 64'(tx_valid), 64'd0);

    // TX burst with stalls and two mid-burst requests coalescing into one extra burst
    rdy_toggle = 1'b1;
    push_burst(in_data);
    pulse_send();
    repeat (20) @(posedge clk);
    check_val("tx2_busy_mid", 64'(tx_busy), 64'd1);
    push_burst(in_data);
    pulse_send();
    repeat (5) @(posedge clk);
    pulse_send();
    wait_drain("tx2", 1'b0, 2000);
    repeat (30) @(posedge clk);
    #1;
    check_val("tx2_no_third", {62'd0, tx_valid, tx_busy}, 64'd0);
    rdy_toggle = 1'b0;

    // Idle timeout inside a frame
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    begin
      int n = 0;
      while (n < RX_TMO + 10 && !frame_error) begin
        @(posedge clk); #1;
        n++;
      end
      check_val("tmo_cycles", 64'(n), 64'(RX_TMO));
    end
    exp_err++;
    check_val("tmo_data", out_data, exp_out);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h55); send_byte(8'h66); send_byte(8'h30);
    exp_out[63:48] = 16'h5566; exp_good++;
    check_val("tmo_next_update", 64'(out_update), 64'h8);
    check_val("tmo_next_data", out_data, exp_out);
    check_stats("tmo");

    // Reset mid-payload: nothing committed, no error, next frame commits
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h77);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_out = '0; exp_good = 0; exp_err = 0;
    check_val("mid_rst_data", out_data, exp_out);
    check_val("mid_rst_flags", {63'd0, frame_error} | 64'(out_update), 64'd0);
    check_stats("mid_rst");
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
    exp_out[15:0] = 16'h1234; exp_good++;
    check_val("post_rst_update", 64'(out_update), 64'h1);
    check_val("post_rst_data", out_data, exp_out);
    check_stats("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
